panel_axi_lite_arbiter: RTL



---
 rtl/panel_axi_lite_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/panel_axi_lite_arbiter.sv
// Round-robin arbiter sharing the panel register AXI4-Lite port
// between two request/done requesters, one transaction at a time.
module panel_axi_lite_arbiter #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          OFFSET_WIDTH = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    req0_valid,
  input  logic                    req0_we,
  input  logic [OFFSET_WIDTH-1:0] req0_offset,
  input  logic [31:0]             req0_wdata,
  output logic                    req0_done,
  output logic [31:0]             req0_rdata,
  output logic [1:0]              req0_resp,
  input  logic                    req1_valid,
  input  logic                    req1_we,
  input  logic [OFFSET_WIDTH-1:0] req1_offset,
  input  logic [31:0]             req1_wdata,
  output logic                    req1_done,
  output logic [31:0]             req1_rdata,
  output logic [1:0]              req1_resp,
  output logic [31:0]             m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [31:0]             m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [31:0]             m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [31:0]             m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int PADW = 32 - OFFSET_WIDTH;

  typedef enum logic [2:0] {
    IDLE, WR, WRESP, RADDR, RDATA, DONE
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [1:0]  resp0_q, resp0_d;
  logic [1:0]  resp1_q, resp1_d;

  logic                    pick;
  logic                    sel_we;
  logic [OFFSET_WIDTH-1:0] sel_off;
  logic [31:0]             sel_wdata;
  logic                    aw_fin;
  logic                    w_fin;

  // On a tie the requester that did not win last time is chosen
  assign pick = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign sel_we    = pick ? req1_we     : req0_we;
  assign sel_off   = pick ? req1_offset : req0_offset;
  assign sel_wdata = pick ? req1_wdata  : req0_wdata;

  // A write channel is finished once its valid is low or handshaking now
  assign aw_fin = ~awvalid_q | m_axi_awready;
  assign w_fin  = ~wvalid_q  | m_axi_wready;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    resp0_d   = resp0_q;
    resp1_d   = resp1_q;
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_d   = pick;
          last_d  = pick;
          addr_d  = BASE_ADDR + {{PADW{1'b0}}, sel_off};
          wdata_d = sel_wdata;
          if (sel_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WR: begin
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q & ~m_axi_wready;
        if (aw_fin && w_fin) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (m_axi_bvalid && bready_q) begin
          bready_d = 1'b0;
          state_d  = DONE;
          if (gnt_q) begin
            done1_d  = 1'b1;
            rdata1_d = 32'h0;
            resp1_d  = m_axi_bresp;
          end else begin
            done0_d  = 1'b1;
            rdata0_d = 32'h0;
            resp0_d  = m_axi_bresp;
          end
        end
      end
      RADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (m_axi_rvalid && rready_q) begin
          rready_d = 1'b0;
          state_d  = DONE;
          if (gnt_q) begin
            done1_d  = 1'b1;
            rdata1_d = m_axi_rdata;
            resp1_d  = m_axi_rresp;
          end else begin
            done0_d  = 1'b1;
            rdata0_d = m_axi_rdata;
            resp0_d  = m_axi_rresp;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
      resp0_q   <= 2'b00;
      resp1_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      resp0_q   <= resp0_d;
      resp1_q   <= resp1_d;
    end
  end

  assign req0_done     = done0_q;
  assign req0_rdata    = rdata0_q;
  assign req0_resp     = resp0_q;
  assign req1_done     = done1_q;
  assign req1_rdata    = rdata1_q;
  assign req1_resp     = resp1_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
